// File: rtl/sseg_display_scheduler.sv
// Digit-tick generator and frame-synchronous arbiter for the 8-digit seven-segment scanner.
// Optional leading-zero blanking of disp_data is enabled by defining SSEG_BLANK_LZ_EN.
module sseg_display_scheduler #(
   parameter int PRESCALE    = 100000,
   parameter int HOLD_FRAMES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        ovr_clear,
   output logic        tc_led,
   output logic [2:0]  scan_idx,
   output logic        frame_tick,
   output logic [31:0] disp_data,
   output logic        override_active
);

   localparam int CNT_W  = $clog2(PRESCALE);
   localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PRESCALE - 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

   typedef enum logic {NORMAL, OVERRIDE} state_t;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [HOLD_W-1:0] hold, hold_next;
   logic              clr_seen, clr_seen_next;
   logic              pend0_valid, pend0_valid_next;
   logic              pend1_valid, pend1_valid_next;
   logic [31:0]       pend0, pend1;
   logic [31:0]       shadow0, shadow_next;
   logic [31:0]       ovr_reg, ovr_next;
   logic [31:0]       disp_reg, disp_next;

`ifdef SSEG_BLANK_LZ_EN
   // Blank each nibble from the top down while it and everything above it is zero.
   function automatic logic [31:0] blank_lz(input logic [31:0] v);
      logic [31:0] r;
      logic        lead;
      r    = v;
      lead = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         if (lead && (v[i*4 +: 4] == 4'h0))
            r[i*4 +: 4] = 4'hF;
         else
            lead = 1'b0;
      end
      return r;
   endfunction
`endif

   assign tc_led     = enable && (cnt == CNT_LAST);
   assign frame_tick = tc_led && (scan_idx == 3'd7);
   assign req0_ready = !pend0_valid;
   assign req1_ready = !pend1_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         scan_idx <= 3'd0;
      end else if (enable) begin
         cnt <= tc_led ? '0 : cnt + CNT_W'(1);
         if (tc_led)
            scan_idx <= scan_idx + 3'd1;
      end
   end

   // Pending slots only load when empty, so capture never races a commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend0 <= '0;
         pend1 <= '0;
      end else begin
         if (req0_valid && req0_ready)
            pend0 <= req0_data;
         if (req1_valid && req1_ready)
            pend1 <= req1_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= NORMAL;
         hold            <= '0;
         clr_seen        <= 1'b0;
         pend0_valid     <= 1'b0;
         pend1_valid     <= 1'b0;
         shadow0         <= '0;
         ovr_reg         <= '0;
         disp_reg        <= '0;
         override_active <= 1'b0;
      end else begin
         state           <= state_next;
         hold            <= hold_next;
         clr_seen        <= clr_seen_next;
         pend0_valid     <= pend0_valid_next;
         pend1_valid     <= pend1_valid_next;
         shadow0         <= shadow_next;
         ovr_reg         <= ovr_next;
         disp_reg        <= disp_next;
         override_active <= (state_next == OVERRIDE);
      end
   end

   always_comb begin
      state_next       = state;
      hold_next        = hold;
      clr_seen_next    = clr_seen | ovr_clear;
      pend0_valid_next = pend0_valid;
      pend1_valid_next = pend1_valid;
      shadow_next      = shadow0;
      ovr_next         = ovr_reg;
      disp_next        = disp_reg;

      if (frame_tick) begin
         clr_seen_next = 1'b0;
         if (pend0_valid) begin
            shadow_next      = pend0;
            pend0_valid_next = 1'b0;
         end
         // A fresh override outranks a clear request at the same boundary.
         if (pend1_valid) begin
            ovr_next         = pend1;
            pend1_valid_next = 1'b0;
            state_next       = OVERRIDE;
            hold_next        = HOLD_INIT;
         end else if (state == OVERRIDE) begin
            if (clr_seen || ovr_clear) begin
               state_next = NORMAL;
               hold_next  = '0;
            end else if (hold == HOLD_W'(1)) begin
               state_next = NORMAL;
               hold_next  = '0;
            end else begin
               hold_next = hold - HOLD_W'(1);
            end
         end
      end

      if (req0_valid && !pend0_valid)
         pend0_valid_next = 1'b1;
      if (req1_valid && !pend1_valid)
         pend1_valid_next = 1'b1;

      disp_next = (state_next == OVERRIDE) ? ovr_next : shadow_next;
   end

`ifdef SSEG_BLANK_LZ_EN
   assign disp_data = blank_lz(disp_reg);
`else
   assign disp_data = disp_reg;
`endif

endmodule

// File: tb/tb_sseg_display_scheduler.sv
// Bench for sseg_display_scheduler: directed timeline table, hand-written corner sequences,
// and randomized traffic checked every cycle against a frame-level reference model.
module tb_sseg_display_scheduler;

   localparam int PRESCALE    = 4;
   localparam int HOLD_FRAMES = 2;
   localparam int FRAME       = 8 * PRESCALE;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        req0_valid = 1'b0;
   logic [31:0] req0_data = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [31:0] req1_data = '0;
   logic        req1_ready;
   logic        ovr_clear = 1'b0;
   logic        tc_led;
   logic [2:0]  scan_idx;
   logic        frame_tick;
   logic [31:0] disp_data;
   logic        override_active;

   sseg_display_scheduler #(.PRESCALE(PRESCALE), .HOLD_FRAMES(HOLD_FRAMES)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .ovr_clear(ovr_clear), .tc_led(tc_led), .scan_idx(scan_idx),
      .frame_tick(frame_tick), .disp_data(disp_data), .override_active(override_active)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: position in the scan is just the number of enabled cycles since reset.
   int          m_ecnt;
   bit          m_p0v, m_p1v, m_ovr_on, m_clr, m_acc0, m_acc1;
   logic [31:0] m_p0, m_p1, m_shadow, m_ovr;
   int          m_frames_left;
   bit          m_frame;

   function automatic logic [31:0] lz(input logic [31:0] v);
`ifdef SSEG_BLANK_LZ_EN
      int n;
      n = 0;
      while (n < 7 && v[31 - 4*n -: 4] == 4'h0) n++;
      return (n == 0) ? v : (v | ~(32'hFFFF_FFFF >> (4*n)));
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ecnt = 0; m_p0v = 0; m_p1v = 0; m_ovr_on = 0; m_clr = 0;
      m_acc0 = 0; m_acc1 = 0; m_p0 = '0; m_p1 = '0; m_shadow = '0; m_ovr = '0;
      m_frames_left = 0;
   endtask

   task automatic step_pre();
      logic        e_tc;
      logic [2:0]  e_scan;
      #2;
      e_tc    = enable && ((m_ecnt % PRESCALE) == PRESCALE - 1);
      e_scan  = 3'((m_ecnt / PRESCALE) % 8);
      m_frame = e_tc && (e_scan == 3'd7);
      chk("tc_led", tc_led, e_tc);
      chk("scan_idx", scan_idx, e_scan);
      chk("frame_tick", frame_tick, m_frame);
      chk("disp_data", disp_data, lz(m_ovr_on ? m_ovr : m_shadow));
      chk("override_active", override_active, m_ovr_on);
      chk("req0_ready", req0_ready, !m_p0v);
      chk("req1_ready", req1_ready, !m_p1v);
   endtask

   task automatic step_post();
      m_acc0 = req0_valid && !m_p0v;
      m_acc1 = req1_valid && !m_p1v;
      if (m_frame) begin
         if (m_p0v) begin m_shadow = m_p0; m_p0v = 0; end
         if (m_p1v) begin
            m_ovr = m_p1; m_p1v = 0; m_ovr_on = 1; m_frames_left = HOLD_FRAMES;
         end else if (m_ovr_on) begin
            if (m_clr || ovr_clear) m_ovr_on = 0;
            else begin
               m_frames_left--;
               if (m_frames_left == 0) m_ovr_on = 0;
            end
         end
         m_clr = 0;
      end else if (ovr_clear) m_clr = 1;
      if (m_acc0) begin m_p0 = req0_data; m_p0v = 1; end
      if (m_acc1) begin m_p1 = req1_data; m_p1v = 1; end
      if (enable) m_ecnt = (m_ecnt + 1) % FRAME;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) begin step_pre(); step_post(); end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      chk("rst_disp", disp_data, lz(32'h0));
      chk("rst_active", override_active, 1'b0);
      chk("rst_ready0", req0_ready, 1'b1);
      chk("rst_ready1", req1_ready, 1'b1);
      chk("rst_tc", tc_led, 1'b0);
      chk("rst_scan", scan_idx, 3'd0);
      chk("rst_frame", frame_tick, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 1;
   endtask

   typedef struct {
      int          cyc;
      bit          v0;
      logic [31:0] d0;
      bit          v1;
      logic [31:0] d1;
      bit          clr;
      logic [31:0] disp;
      bit          act;
      bit          r0;
      bit          r1;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(int c, bit v0, logic [31:0] d0, bit v1, logic [31:0] d1, bit clr,
                               logic [31:0] disp, bit act, bit r0, bit r1);
      vec_t v;
      v.cyc = c; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.clr = clr;
      v.disp = lz(disp); v.act = act; v.r0 = r0; v.r1 = r1;
      return v;
   endfunction

   initial begin
      // Inputs in each row stay applied until the next row's cycle.
      vq.push_back(mk(  1, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1));
      vq.push_back(mk(  5, 1, 32'h12345678, 0, 0, 0, 32'h0, 0, 1, 1));
      vq.push_back(mk(  6, 1, 32'h00000042, 0, 0, 0, 32'h0, 0, 0, 1));
      vq.push_back(mk( 32, 1, 32'h00000042, 0, 0, 0, 32'h0, 0, 0, 1));
      vq.push_back(mk( 33, 1, 32'h00000042, 0, 0, 0, 32'h12345678, 0, 1, 1));
      vq.push_back(mk( 34, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 1));
      vq.push_back(mk( 40, 0, 0, 1, 32'hDEADBEEF, 0, 32'h12345678, 0, 0, 1));
      vq.push_back(mk( 41, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 0));
      vq.push_back(mk( 64, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 0));
      vq.push_back(mk( 65, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 1));
      vq.push_back(mk( 96, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 1));
      vq.push_back(mk( 97, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 1));
      vq.push_back(mk(128, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 1));
      vq.push_back(mk(129, 0, 0, 0, 0, 0, 32'h00000042, 0, 1, 1));
      vq.push_back(mk(130, 0, 0, 1, 32'hCAFEF00D, 0, 32'h00000042, 0, 1, 1));
      vq.push_back(mk(131, 0, 0, 0, 0, 0, 32'h00000042, 0, 1, 0));
      vq.push_back(mk(161, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 1, 1));
      vq.push_back(mk(170, 0, 0, 0, 0, 1, 32'hCAFEF00D, 1, 1, 1));
      vq.push_back(mk(171, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 1, 1));
      vq.push_back(mk(192, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1, 1, 1));
      vq.push_back(mk(193, 0, 0, 0, 0, 0, 32'h00000042, 0, 1, 1));
      vq.push_back(mk(194, 0, 0, 1, 32'h0BADF00D, 0, 32'h00000042, 0, 1, 1));
      vq.push_back(mk(195, 0, 0, 0, 0, 0, 32'h00000042, 0, 1, 0));
      vq.push_back(mk(225, 0, 0, 0, 0, 0, 32'h0BADF00D, 1, 1, 1));
      vq.push_back(mk(230, 0, 0, 1, 32'h55AA0000, 0, 32'h0BADF00D, 1, 1, 1));
      vq.push_back(mk(231, 0, 0, 0, 0, 1, 32'h0BADF00D, 1, 1, 0));
      vq.push_back(mk(232, 0, 0, 0, 0, 0, 32'h0BADF00D, 1, 1, 0));
      vq.push_back(mk(256, 0, 0, 0, 0, 0, 32'h0BADF00D, 1, 1, 0));
      vq.push_back(mk(257, 0, 0, 0, 0, 0, 32'h55AA0000, 1, 1, 1));
      vq.push_back(mk(289, 0, 0, 0, 0, 0, 32'h55AA0000, 1, 1, 1));
      vq.push_back(mk(320, 0, 0, 0, 0, 0, 32'h55AA0000, 1, 1, 1));
      vq.push_back(mk(321, 0, 0, 0, 0, 0, 32'h00000042, 0, 1, 1));

      #1;
      apply_reset();

      foreach (vq[k]) begin
         idle_until(vq[k].cyc);
         req0_valid = vq[k].v0; req0_data = vq[k].d0;
         req1_valid = vq[k].v1; req1_data = vq[k].d1;
         ovr_clear  = vq[k].clr;
         step_pre();
         chk("tbl_disp", disp_data, vq[k].disp);
         chk("tbl_active", override_active, vq[k].act);
         chk("tbl_ready0", req0_ready, vq[k].r0);
         chk("tbl_ready1", req1_ready, vq[k].r1);
         step_post();
      end

      // Prescaler freeze mid-frame: scan position 2, handshake still completes.
      idle_until(330);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         req0_valid = (cyc == 335);
         req0_data  = 32'h00000077;
         step_pre();
         chk("frz_tc", tc_led, 1'b0);
         chk("frz_scan", scan_idx, 3'd2);
         if (cyc == 336) begin
            chk("frz_ready0", req0_ready, 1'b0);
            chk("frz_disp", disp_data, lz(32'h00000042));
         end
         step_post();
      end
      req0_valid = 1'b0;
      enable = 1'b1;
      idle_until(352);
      step_pre();
      chk("resume_tc", tc_led, 1'b1);
      chk("resume_scan", scan_idx, 3'd2);
      step_post();
      idle_until(372);
      step_pre();
      chk("resume_frame", frame_tick, 1'b1);
      step_post();
      req1_valid = 1'b1; req1_data = 32'h00000099;
      step_pre();
      chk("resume_disp", disp_data, lz(32'h00000077));
      step_post();
      req1_valid = 1'b0;
      idle_until(405);
      step_pre();
      chk("ovr2_active", override_active, 1'b1);
      chk("ovr2_disp", disp_data, lz(32'h00000099));
      step_post();
      req0_valid = 1'b1; req0_data = 32'h00000005;
      step_pre(); step_post();
      req0_valid = 1'b0;
      step_pre();
      chk("pre_rst_ready0", req0_ready, 1'b0);
      step_post();
      idle_until(410);
      apply_reset();

      // Randomized traffic; requesters hold valid/data until accepted.
      for (int i = 0; i < 3500; i++) begin
         if (i == 1800) apply_reset();
         enable = ($urandom_range(0, 9) != 0);
         if (!req0_valid && $urandom_range(0, 5) == 0) begin
            req0_valid = 1'b1;
            req0_data  = $urandom >> $urandom_range(0, 31);
         end
         if (!req1_valid && $urandom_range(0, 20) == 0) begin
            req1_valid = 1'b1;
            req1_data  = $urandom >> $urandom_range(0, 31);
         end
         ovr_clear = ($urandom_range(0, 40) == 0);
         step_pre();
         step_post();
         if (m_acc0) req0_valid = 1'b0;
         if (m_acc1) req1_valid = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
